// File: rtl/sfp_mon_int.sv
// sfp_mon_int: SFP presence (ABS) and loss-of-signal (LOS) monitor for CH_NUM
// optical channels. The raw pins are synchronised and then debounced on
// sample_tick. Qualified status edges are latched into per-type pending
// registers, and these drive one registered active-low interrupt.
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   sample_tick             one-clk debounce sampling strobe
//   abs_pin, los_pin        raw asynchronous SFP pins (CH_NUM each)
//   edge_mode               00 rising, 01 falling, 10 both, 11 no events
//   int_mask                per-channel interrupt mask (1 = masked)
//   glb_mask                1 = hold int_n high
//   rd_clr, rd_sel          clear pulse for the ABS (0) or LOS (1) pending reg
//   abs_status, los_status  debounced pin levels
//   abs_pend, los_pend      latched events
//   int_n                   aggregate interrupt, active low
module sfp_mon_int #(
    parameter int CH_NUM  = 8,
    parameter int DEB_CNT = 3,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_tick,
    input  logic [CH_NUM-1:0] abs_pin,
    input  logic [CH_NUM-1:0] los_pin,
    input  logic [1:0]        edge_mode,
    input  logic [CH_NUM-1:0] int_mask,
    input  logic              glb_mask,
    input  logic              rd_clr,
    input  logic              rd_sel,
    output logic [CH_NUM-1:0] abs_status,
    output logic [CH_NUM-1:0] los_status,
    output logic [CH_NUM-1:0] abs_pend,
    output logic [CH_NUM-1:0] los_pend,
    output logic              int_n
);

    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CH_NUM-1:0] abs_meta_q, abs_sync_q, los_meta_q, los_sync_q;
    logic              primed_q, primed_d;
    logic [CH_NUM-1:0] abs_stat_q, abs_stat_d, los_stat_q, los_stat_d;
    logic [CH_NUM-1:0][CNT_W-1:0] abs_cnt_q, abs_cnt_d, los_cnt_q, los_cnt_d;
    logic [CH_NUM-1:0] abs_pend_q, abs_pend_d, los_pend_q, los_pend_d;
    logic              int_n_q, int_n_d;

    logic [CH_NUM-1:0] abs_chg, los_chg;
    logic [CH_NUM-1:0] abs_set, los_set, abs_clr, los_clr;
    logic              qual_rise, qual_fall;

    // Debounce. The first tick after reset only primes the status vectors.
    // A level must differ from status on DEB_CNT consecutive ticks before it
    // is accepted. Any tick that matches status restarts the count.
    always_comb begin
        primed_d   = primed_q;
        abs_stat_d = abs_stat_q;
        los_stat_d = los_stat_q;
        abs_cnt_d  = abs_cnt_q;
        los_cnt_d  = los_cnt_q;
        abs_chg    = '0;
        los_chg    = '0;
        if (sample_tick) begin
            if (!primed_q) begin
                abs_stat_d = abs_sync_q;
                los_stat_d = los_sync_q;
                primed_d   = 1'b1;
            end else begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (abs_sync_q[i] == abs_stat_q[i]) begin
                        abs_cnt_d[i] = '0;
                    end else if (abs_cnt_q[i] == DEB_TC) begin
                        abs_stat_d[i] = abs_sync_q[i];
                        abs_cnt_d[i]  = '0;
                        abs_chg[i]    = 1'b1;
                    end else begin
                        abs_cnt_d[i] = abs_cnt_q[i] + CNT_ONE;
                    end

                    if (los_sync_q[i] == los_stat_q[i]) begin
                        los_cnt_d[i] = '0;
                    end else if (los_cnt_q[i] == DEB_TC) begin
                        los_stat_d[i] = los_sync_q[i];
                        los_cnt_d[i]  = '0;
                        los_chg[i]    = 1'b1;
                    end else begin
                        los_cnt_d[i] = los_cnt_q[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    assign qual_rise = (edge_mode == 2'b00) || (edge_mode == 2'b10);
    assign qual_fall = (edge_mode == 2'b01) || (edge_mode == 2'b10);

    // The new status level tells the direction of an accepted change.
    assign abs_set = abs_chg & (({CH_NUM{qual_rise}} &  abs_stat_d) |
                                ({CH_NUM{qual_fall}} & ~abs_stat_d));
    assign los_set = los_chg & (({CH_NUM{qual_rise}} &  los_stat_d) |
                                ({CH_NUM{qual_fall}} & ~los_stat_d));

    assign abs_clr = {CH_NUM{rd_clr & ~rd_sel}};
    assign los_clr = {CH_NUM{rd_clr &  rd_sel}};

    // The set term is applied after the clear so that an event arriving with
    // a read-clear is not lost.
    assign abs_pend_d = (abs_pend_q & ~abs_clr) | abs_set;
    assign los_pend_d = (los_pend_q & ~los_clr) | los_set;

    assign int_n_d = ~(~glb_mask & (|((abs_pend_q | los_pend_q) & ~int_mask)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_meta_q <= '0;
            abs_sync_q <= '0;
            los_meta_q <= '0;
            los_sync_q <= '0;
            primed_q   <= 1'b0;
            abs_stat_q <= '0;
            los_stat_q <= '0;
            abs_cnt_q  <= '0;
            los_cnt_q  <= '0;
            abs_pend_q <= '0;
            los_pend_q <= '0;
            int_n_q    <= 1'b1;
        end else begin
            abs_meta_q <= abs_pin;
            abs_sync_q <= abs_meta_q;
            los_meta_q <= los_pin;
            los_sync_q <= los_meta_q;
            primed_q   <= primed_d;
            abs_stat_q <= abs_stat_d;
            los_stat_q <= los_stat_d;
            abs_cnt_q  <= abs_cnt_d;
            los_cnt_q  <= los_cnt_d;
            abs_pend_q <= abs_pend_d;
            los_pend_q <= los_pend_d;
            int_n_q    <= int_n_d;
        end
    end

    assign abs_status = abs_stat_q;
    assign los_status = los_stat_q;
    assign abs_pend   = abs_pend_q;
    assign los_pend   = los_pend_q;
    assign int_n      = int_n_q;

endmodule

// File: tb/tb_sfp_mon_int.sv
// Bench for sfp_mon_int. The behavioural model works with per-channel run
// lengths and a two-deep pin history. It is compared with the DUT on every
// falling clock edge. Directed literal checks pin down the test-plan cases,
// and a randomised phase follows them.
module tb_sfp_mon_int;

    localparam int CH  = 8;
    localparam int DEB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_tick;
    logic [CH-1:0] abs_pin, los_pin;
    logic [1:0]    edge_mode;
    logic [CH-1:0] int_mask;
    logic          glb_mask;
    logic          rd_clr, rd_sel;
    logic [CH-1:0] abs_status, los_status, abs_pend, los_pend;
    logic          int_n;

    int n_checks = 0;
    int n_errors = 0;

    sfp_mon_int #(.CH_NUM(CH), .DEB_CNT(DEB), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .abs_pin(abs_pin), .los_pin(los_pin), .edge_mode(edge_mode),
        .int_mask(int_mask), .glb_mask(glb_mask), .rd_clr(rd_clr),
        .rd_sel(rd_sel), .abs_status(abs_status), .los_status(los_status),
        .abs_pend(abs_pend), .los_pend(los_pend), .int_n(int_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [CH-1:0] h1_abs, h2_abs, h1_los, h2_los;   // pin seen 1 and 2 edges ago
    logic [CH-1:0] m_abs_st, m_los_st, m_abs_pd, m_los_pd;
    logic          m_primed, m_int_n;
    int            m_abs_run [CH];
    int            m_los_run [CH];

    always @(posedge clk or negedge rst_n) begin
        logic [CH-1:0] sa, sl, aset, lset;
        logic          rise_ok, fall_ok, new_int_n;
        if (!rst_n) begin
            h1_abs = '0; h2_abs = '0; h1_los = '0; h2_los = '0;
            m_abs_st = '0; m_los_st = '0; m_abs_pd = '0; m_los_pd = '0;
            m_primed = 1'b0; m_int_n = 1'b1;
            for (int c = 0; c < CH; c++) begin
                m_abs_run[c] = 0;
                m_los_run[c] = 0;
            end
        end else begin
            sa = h2_abs; sl = h2_los;
            h2_abs = h1_abs; h1_abs = abs_pin;
            h2_los = h1_los; h1_los = los_pin;
            new_int_n = !(!glb_mask && (((m_abs_pd | m_los_pd) & ~int_mask) != 0));
            rise_ok = (edge_mode == 2'd0) || (edge_mode == 2'd2);
            fall_ok = (edge_mode == 2'd1) || (edge_mode == 2'd2);
            aset = '0; lset = '0;
            if (sample_tick) begin
                if (!m_primed) begin
                    m_abs_st = sa; m_los_st = sl; m_primed = 1'b1;
                end else begin
                    for (int c = 0; c < CH; c++) begin
                        if (sa[c] != m_abs_st[c]) begin
                            m_abs_run[c]++;
                            if (m_abs_run[c] >= DEB) begin
                                m_abs_st[c] = sa[c];
                                m_abs_run[c] = 0;
                                aset[c] = sa[c] ? rise_ok : fall_ok;
                            end
                        end else m_abs_run[c] = 0;
                        if (sl[c] != m_los_st[c]) begin
                            m_los_run[c]++;
                            if (m_los_run[c] >= DEB) begin
                                m_los_st[c] = sl[c];
                                m_los_run[c] = 0;
                                lset[c] = sl[c] ? rise_ok : fall_ok;
                            end
                        end else m_los_run[c] = 0;
                    end
                end
            end
            if (rd_clr && !rd_sel) m_abs_pd = '0;
            if (rd_clr &&  rd_sel) m_los_pd = '0;
            m_abs_pd = m_abs_pd | aset;
            m_los_pd = m_los_pd | lset;
            m_int_n  = new_int_n;
        end
    end

    always @(negedge clk) begin
        chk("model abs_status", 32'(abs_status), 32'(m_abs_st));
        chk("model los_status", 32'(los_status), 32'(m_los_st));
        chk("model abs_pend",   32'(abs_pend),   32'(m_abs_pd));
        chk("model los_pend",   32'(los_pend),   32'(m_los_pd));
        chk("model int_n",      32'(int_n),      32'(m_int_n));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit tk, input bit clr, input bit sel);
        sample_tick = tk; rd_clr = clr; rd_sel = sel;
        @(posedge clk);
        #2;
        sample_tick = 1'b0; rd_clr = 1'b0;
    endtask

    task automatic accept(input int n);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int k = 0; k < n; k++) step(1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; sample_tick = 1'b0; rd_clr = 1'b0; rd_sel = 1'b0;
        abs_pin = 8'hFF; los_pin = 8'h00; edge_mode = 2'b00;
        int_mask = '0; glb_mask = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset abs_status", 32'(abs_status), 32'h0);
        chk("reset abs_pend",   32'(abs_pend),   32'h0);
        chk("reset int_n",      32'(int_n),      32'h1);
        rst_n = 1'b1;

        // prime
        accept(1);
        chk("prime abs_status", 32'(abs_status), 32'hFF);
        chk("prime abs_pend",   32'(abs_pend),   32'h00);
        step(0, 0, 0);
        chk("prime int_n",      32'(int_n),      32'h1);

        // debounce accept on los[2]
        los_pin = 8'h04;
        accept(2);
        chk("deb 2 ticks los_status", 32'(los_status), 32'h00);
        step(1, 0, 0);
        chk("deb los_status", 32'(los_status), 32'h04);
        chk("deb los_pend",   32'(los_pend),   32'h04);
        chk("deb int_n lag",  32'(int_n),      32'h1);
        step(0, 0, 0);
        chk("deb int_n",      32'(int_n),      32'h0);
        step(0, 1, 1);
        chk("clr los_pend",   32'(los_pend),   32'h00);
        step(0, 0, 0);
        chk("clr int_n",      32'(int_n),      32'h1);

        // glitch on los[5]: two ticks high then low, counter must restart
        los_pin = 8'h24;
        accept(2);
        los_pin = 8'h04;
        accept(1);
        chk("glitch los_status", 32'(los_status), 32'h04);
        chk("glitch los_pend",   32'(los_pend),   32'h00);
        chk("glitch int_n",      32'(int_n),      32'h1);
        los_pin = 8'h24;
        accept(2);
        chk("restart los_status", 32'(los_status), 32'h04);
        step(1, 0, 0);
        chk("restart accept", 32'(los_status), 32'h24);
        step(0, 1, 1);

        // masking
        abs_pin = 8'hFD;
        accept(3);
        chk("fall mode00 pend", 32'(abs_pend), 32'h00);
        int_mask = 8'h02;
        abs_pin = 8'hFF;
        accept(3);
        chk("mask abs_pend", 32'(abs_pend), 32'h02);
        step(0, 0, 0);
        chk("masked int_n", 32'(int_n), 32'h1);
        int_mask = 8'h00;
        step(0, 0, 0);
        chk("unmask int_n", 32'(int_n), 32'h0);
        glb_mask = 1'b1;
        step(0, 0, 0);
        chk("glb_mask int_n", 32'(int_n), 32'h1);
        glb_mask = 1'b0;
        step(0, 1, 0);
        chk("abs clr", 32'(abs_pend), 32'h00);

        // set wins over clear
        abs_pin = 8'hF6;
        accept(3);
        abs_pin = 8'hF7;
        accept(3);
        chk("sw pre pend", 32'(abs_pend), 32'h01);
        abs_pin = 8'hFF;
        accept(2);
        step(1, 1, 0);
        chk("set wins abs_pend", 32'(abs_pend), 32'h08);
        step(0, 0, 0);
        chk("set wins int_n", 32'(int_n), 32'h0);
        step(0, 1, 0);
        chk("sw clear", 32'(abs_pend), 32'h00);
        step(0, 0, 0);
        chk("sw int_n release", 32'(int_n), 32'h1);

        // edge modes on abs[0]
        edge_mode = 2'b11; abs_pin = 8'hFE; accept(3);
        edge_mode = 2'b01; abs_pin = 8'hFF; accept(3);
        chk("mode01 rise pend", 32'(abs_pend), 32'h00);
        abs_pin = 8'hFE; accept(3);
        chk("mode01 fall pend", 32'(abs_pend), 32'h01);
        step(0, 1, 0);
        edge_mode = 2'b10; abs_pin = 8'hFF; accept(3);
        chk("mode10 rise pend", 32'(abs_pend), 32'h01);
        step(0, 1, 0);
        abs_pin = 8'hFE; accept(3);
        chk("mode10 fall pend", 32'(abs_pend), 32'h01);
        step(0, 1, 0);
        edge_mode = 2'b11; abs_pin = 8'hFF; accept(3);
        chk("mode11 status", 32'(abs_status), 32'hFF);
        chk("mode11 pend",   32'(abs_pend),   32'h00);

        // reset mid-debounce, then priming repeats
        edge_mode = 2'b00;
        los_pin = 8'hA4;
        accept(1);
        rst_n = 1'b0;
        #1;
        chk("midrst los_status", 32'(los_status), 32'h00);
        chk("midrst int_n",      32'(int_n),      32'h1);
        step(0, 0, 0);
        rst_n = 1'b1;
        accept(1);
        chk("reprime los_status", 32'(los_status), 32'hA4);
        chk("reprime los_pend",   32'(los_pend),   32'h00);

        // randomised phase against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(0, 39) == 0) abs_pin[b] = ~abs_pin[b];
                if ($urandom_range(0, 39) == 0) los_pin[b] = ~los_pin[b];
            end
            if (c % 300 == 0) edge_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) int_mask = 8'($urandom);
            glb_mask = ($urandom_range(0, 15) == 0);
            if (c == 1500) begin
                rst_n = 1'b0;
                step(0, 0, 0);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)));
        end

        step(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sfp_mon_int.md
Name:
sfp_mon_int

Overview:
Parametrised SFP presence (ABS) and loss-of-signal (LOS) monitor with interrupt generation, for N optical channels. It synchronises and debounces the raw pins and latches edge-qualified events into per-type pending registers. Pending bits clear when the local-bus block reads them. It drives a single active-low interrupt to the local-bus interface.

Parameters:
CH_NUM, 8, number of SFP channels (1..32)
DEB_CNT, 3, consecutive sample ticks a new pin level must hold before it is accepted (>=1)
CNT_W, 2, debounce counter width; must satisfy 2^CNT_W >= DEB_CNT

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-clk sampling strobe (100 Hz tick from clk_gen)
abs_pin  input  CH_NUM  raw SFP ABS pins, asynchronous
los_pin  input  CH_NUM  raw SFP LOS pins, asynchronous
edge_mode  input  2  00 rising, 01 falling, 10 both, 11 events disabled
int_mask  input  CH_NUM  per-channel mask, 1 = masked; applies to both types
glb_mask  input  1  1 = int_n held high
rd_clr  input  1  one-clk pulse; clears the pending register selected by rd_sel
rd_sel  input  1  0 = ABS pending, 1 = LOS pending
abs_status  output  CH_NUM  debounced ABS level
los_status  output  CH_NUM  debounced LOS level
abs_pend  output  CH_NUM  latched ABS events
los_pend  output  CH_NUM  latched LOS events
int_n  output  1  aggregate interrupt, active low

Behaviour:
- Clock and reset: single clock domain clk; reset rst_n is asynchronous and active-low.
- Reset values: status=0, pend=0, debounce counters=0, primed=0, int_n=1, synchroniser flops=0.
- Synchroniser: each pin passes through 2 flops on every clk.
- Priming: the first sample_tick after reset loads both status vectors directly from the synchronised pins and sets primed=1. This load generates no events.
- Debounce, per channel and per type, evaluated only on sample_tick with primed=1:
  - sync==status: counter <= 0.
  - sync!=status and counter==DEB_CNT-1: status <= sync, counter <= 0, raise the event candidate.
  - otherwise: counter <= counter+1.
  - With DEB_CNT=1, a pin level is accepted on the first differing tick.
- Event qualification:
  - rising = status 0->1, falling = 1->0.
  - An event is latched when it matches edge_mode. With edge_mode=11, pend is not set but status still tracks.
  - int_mask does not gate latching; it gates only int_n.
- Pending update happens on the same clk edge as the status update: pend <= (pend & ~clr_vec) | set_vec.
  - clr_vec is all-ones for the selected type when rd_clr=1, zero otherwise.
  - Set wins when set and clear coincide on a bit, so no event is lost.
  - rd_clr has no effect on the unselected type.
- int_n is registered: int_n <= ~(~glb_mask & |(((abs_pend|los_pend) & ~int_mask))).
  - It lags pend by 1 clk.
  - Unmasking a channel that is already pending drives int_n low 1 clk later.
- Latency from a pin edge to the status update: 2 clk sync, then the DEB_CNT-th sample_tick that sees the new level. int_n follows 1 clk after that.
- Glitches shorter than DEB_CNT consecutive ticks are discarded; the counter restarts at 0.
- Reset asserted mid-debounce drops all state immediately. Priming repeats after release.
- sample_tick and rd_clr may coincide; both take effect on the same edge under the set-wins rule.

Test Plan:
- Prime: reset, abs_pin=0xFF, then 1 tick -> abs_status=0xFF, abs_pend=0x00, int_n=1.
- Debounce accept: DEB_CNT=3, edge_mode=00, primed with los_pin=0x00, raise los_pin[2] and hold for 3 ticks -> los_status=0x04, los_pend=0x04 on the 3rd tick, int_n=0 one clk later.
- Glitch reject: los_pin[5] high for 2 ticks, then low -> los_status[5]=0, los_pend unchanged, int_n unchanged.
- Masking: abs_pend[1] set, int_mask=0x02 -> int_n=1. Clear int_mask to 0x00 -> int_n=0 next clk. Set glb_mask=1 -> int_n=1.
- Set-wins: rd_clr=1, rd_sel=0 on the same edge as a new abs[3] event while abs_pend=0x01 -> abs_pend=0x08. A following rd_clr clears it to 0x00 and int_n returns to 1.
- Edge modes: edge_mode=01 with 0->1 then 1->0 on abs[0] -> event only on the fall. edge_mode=10 -> both edges latch. edge_mode=11 -> status follows the pin, pend stays 0.
